bram_port_arbiter: RTL
======================

// Module: bram_port_arbiter
// PURPOSE
// - Shares one BRAM port (addr/we/din/dout, 1-cycle registered read) between two requesters.
// - M0 is the CPU data path. M1 is the UART debug loader/reader.
// - Round-robin arbitration, one transaction per grant; the BRAM port signals are driven from registers.
// - Sits between the requesters and the memory port the UART loader drives today.
// PARAMETERS
// ADDR_WIDTH  16  BRAM word-address width
// DATA_WIDTH  32  data width; byte-strobe width = DATA_WIDTH/8
// PORTS
// clk        in   1      clock, all logic on posedge
// rst        in   1      synchronous reset, active-high
// m0_req     in   1      M0 request; hold high with stable payload until m0_done
// m0_addr    in   ADDR_WIDTH  M0 address
// m0_wstrb   in   DATA_WIDTH/8  M0 byte enables; 0 = read, nonzero = write
// m0_wdata   in   DATA_WIDTH  M0 write data
// m0_done    out  1      1-cycle pulse: M0 transaction complete (read data valid on rdata)
// m1_req, m1_addr, m1_wstrb, m1_wdata, m1_done: same as M0, for M1
// rdata      out  DATA_WIDTH  read data for the finishing read, valid while mX_done=1
// bram_addr  out  ADDR_WIDTH  BRAM address (registered)
// bram_we    out  DATA_WIDTH/8  BRAM byte write enables (registered)
// bram_din   out  DATA_WIDTH  BRAM write data (registered)
// bram_dout  in   DATA_WIDTH  BRAM read data, valid 1 cycle after bram_addr is sampled
// busy       out  1      high whenever state != ARB
// owner      out  1      requester of the current or last transaction (0=M0, 1=M1)
// BEHAVIOUR
// - Reset values:
//   - state=ARB; bram_addr=0, bram_we=0, bram_din=0, rdata=0.
//   - m0_done=m1_done=0, busy=0, owner=1, so M0 wins the first tie.
// - FSM states: ARB, ISSUE, WAIT.
// - ARB (cycle N), if any req is high:
//   - Winner: the single requester if only one is high.
//   - If both are high, the winner is !owner (round-robin).
//   - Register owner, bram_addr, bram_we (=wstrb) and bram_din from the winner.
//   - Go to ISSUE. No req high: stay in ARB, keep bram_we=0.
// - ISSUE (N+1): the BRAM samples the port.
//   - Clear bram_we at the end of this cycle.
//   - Write: pulse done[owner] in cycle N+2, then go to ARB.
//   - Read: go to WAIT.
// - WAIT (N+2): register rdata<=bram_dout, pulse done[owner] in cycle N+3, then go to ARB.
// - Latency from req sampled in ARB to done: write 2 cycles, read 3 cycles.
//   - Back-to-back throughput: one write per 2 cycles, one read per 3 cycles.
// - done is a single-cycle pulse. It is never asserted for the non-owner.
// - rdata holds its value until the next read completes. Writes leave rdata unchanged.
// - A requester may reassert or keep req in the same cycle done is high.
//   - That cycle is ARB, so a re-request is evaluated against round-robin immediately.
// - A req dropped after its grant is ignored: the transaction completes and done still pulses.
// - A req that changes payload mid-transaction is ignored: payload is captured only in ARB.
// - Under both reqs continuously high, grants alternate strictly M0,M1,M0,...; no starvation.
// - bram_we is nonzero only during the ISSUE cycle of a write.
// - Reset mid-transaction:
//   - Abort; return to ARB; bram_we=0.
//   - No done pulse for the aborted transaction.
//   - owner returns to 1.
// - Address/strobe widths pass straight through. No range check; the BRAM wraps per its own depth.
// TESTING
// - Single write:
//   - M0 req, addr=0x0010, wstrb=4'hF, wdata=0xDEADBEEF.
//   - bram_we=F one cycle; m0_done 2 cycles after req sampled.
//   - A later M1 read of 0x0010 returns rdata=0xDEADBEEF with m1_done.
// - Byte write:
//   - Write wstrb=4'h2, wdata=0x0000AB00 over 0x11223344.
//   - Readback gives 0x1122AB44.
// - Contention:
//   - m0_req and m1_req held high from reset with reads.
//   - Grants go M0,M1,M0,M1; done pulses alternate every 3 cycles; busy stays high except ARB cycles.
// - Dropped request: M1 read granted, then m1_req deasserts in ISSUE.
//   - m1_done still pulses at N+3 with correct data.
//   - m0 sees no done.
// - Reset mid-read: assert rst during WAIT.
//   - No done pulse; bram_we=0; next cycle after release busy=0, owner=1.
//   - A subsequent tie grants M0.
// - Write then read same address from different masters, back-to-back:
//   - M0 write 0x0005=0xCAFEF00D, M1 read 0x0005 queued.
//   - M1 receives 0xCAFEF00D.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bundle for the BRAM port arbiter.
// master: requester drives req/addr/wstrb/wdata, receives done.
// slave:  arbiter samples req/addr/wstrb/wdata, drives done.
interface bram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                      req;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      done;

    modport master (
        output req, addr, wstrb, wdata,
        input  done
    );

    modport slave (
        input  req, addr, wstrb, wdata,
        output done
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one registered BRAM port between M0 and M1.
// Ports: clk, rst (sync, active-high), m0/m1 requester bundles, rdata,
// bram_addr/bram_we/bram_din (registered), bram_dout, busy, owner.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    bram_port_arbiter_if.slave      m0,
    bram_port_arbiter_if.slave      m1,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH/8-1:0] bram_we,
    output logic [DATA_WIDTH-1:0]   bram_din,
    input  logic [DATA_WIDTH-1:0]   bram_dout,
    output logic                    busy,
    output logic                    owner
);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SW-1:0]         we_q, we_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            done_q, done_d;
    logic                  win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            owner_q <= 1'b1;
            addr_q  <= '0;
            we_q    <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = '0;
        din_d   = din_q;
        rdata_d = rdata_q;
        done_d  = '0;
        win     = owner_q;
        unique case (state_q)
            ARB: begin
                if (m0.req || m1.req) begin
                    // On a tie the last owner yields.
                    win     = (m0.req && m1.req) ? ~owner_q : m1.req;
                    owner_d = win;
                    addr_d  = win ? m1.addr  : m0.addr;
                    we_d    = win ? m1.wstrb : m0.wstrb;
                    din_d   = win ? m1.wdata : m0.wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Writes finish here; reads need one more cycle for dout.
                if (we_q != '0) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = ARB;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rdata_d         = bram_dout;
                done_d[owner_q] = 1'b1;
                state_d         = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    assign m0.done   = done_q[0];
    assign m1.done   = done_q[1];
    assign rdata     = rdata_q;
    assign bram_addr = addr_q;
    assign bram_we   = we_q;
    assign bram_din  = din_q;
    assign busy      = (state_q != ARB);
    assign owner     = owner_q;
endmodule
